// File: rtl/pll_seq_pkg.sv
// Shared opcodes, FSM states and error codes for the PLL SPI bring-up sequencer.
package pll_seq_pkg;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_RMW   = 3'd2;
  localparam logic [2:0] OP_POLL  = 3'd3;
  localparam logic [2:0] OP_CHECK = 3'd4;
  localparam logic [2:0] OP_WAIT  = 3'd5;
  localparam logic [2:0] OP_END   = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CHECK   = 2'd2;
  localparam logic [1:0] ERR_POLL    = 2'd3;

  typedef enum logic [2:0] {
    StHold,
    StFetch,
    StIssue,
    StWaitDone,
    StEval,
    StDelay,
    StDone,
    StFail
  } state_e;

endpackage

// File: rtl/seq_countdown.sv
// Loadable down-counter that stops at zero and flags it.
module seq_countdown #(
  parameter int          W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pll_spi_sequencer.sv
// Script-driven SPI register sequencer: holds the PLL in reset, then runs
// write/read/RMW/poll/check/wait steps from an external ROM and reports status.
module pll_spi_sequencer
  import pll_seq_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int N_STEPS      = 16,
  parameter int N_CAPT       = 8,
  parameter int RESET_WAIT   = 200,
  parameter int DONE_TIMEOUT = 4096,
  parameter int POLL_MAX     = 256,
  localparam int STEP_W      = $clog2(N_STEPS),
  localparam int CAPT_W      = $clog2(N_CAPT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [STEP_W-1:0]        step_idx,
  input  logic [2:0]               step_op,
  input  logic [ADDR_W-1:0]        step_addr,
  input  logic [DATA_W-1:0]        step_data,
  input  logic [DATA_W-1:0]        step_mask,
  input  logic [CAPT_W-1:0]        step_capt,
  output logic                     if_read,
  output logic                     if_write,
  output logic [ADDR_W-1:0]        if_addr,
  output logic [DATA_W-1:0]        if_wdata,
  input  logic [DATA_W-1:0]        if_rdata,
  input  logic                     if_done,
  output logic                     if_reset,
  output logic                     pll_reset,
  output logic [N_CAPT*DATA_W-1:0] capt_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [STEP_W-1:0]        err_step,
  output logic [1:0]               err_code
);

  localparam int HOLD_W = $clog2(RESET_WAIT + 1);
  localparam int TO_W   = $clog2(DONE_TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_WAIT - 1);
  localparam logic [TO_W-1:0]   TO_INIT   = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_INIT = POLL_W'(POLL_MAX - 1);

  state_e             r_state;
  logic [STEP_W-1:0]  r_step_idx, r_err_step;
  logic [1:0]         r_err_code;
  logic               r_done, r_error, r_pll_reset, r_if_reset;
  logic               r_if_read, r_if_write, r_rmw_wr;
  logic [ADDR_W-1:0]  r_if_addr;
  logic [DATA_W-1:0]  r_if_wdata, r_rdata;
  logic [DATA_W-1:0]  r_capt [N_CAPT];

  logic               w_start_ok, w_last, w_hit;
  logic               w_hold_zero, w_to_zero, w_dly_zero, w_poll_zero;
  state_e             w_adv_state;
  logic [STEP_W-1:0]  w_adv_idx;

  assign w_start_ok  = start && ((r_state == StDone) || (r_state == StFail));
  assign w_last      = (r_step_idx == STEP_W'(N_STEPS - 1));
  assign w_adv_state = w_last ? StDone : StFetch;
  assign w_adv_idx   = w_last ? r_step_idx : r_step_idx + STEP_W'(1);
  // Shared by POLL and CHECK: only masked bits take part in the compare.
  assign w_hit       = ((r_rdata ^ step_data) & step_mask) == '0;

  seq_countdown #(.W(HOLD_W), .RST_VAL(HOLD_INIT)) u_hold_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_start_ok),
    .i_load_val (HOLD_INIT),
    .i_dec      (r_state == StHold),
    .o_zero     (w_hold_zero)
  );

  seq_countdown #(.W(TO_W), .RST_VAL(TO_INIT)) u_timeout_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (r_state == StIssue),
    .i_load_val (TO_INIT),
    .i_dec      (r_state == StWaitDone),
    .o_zero     (w_to_zero)
  );

  seq_countdown #(.W(DATA_W), .RST_VAL('0)) u_delay_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     ((r_state == StFetch) && (step_op == OP_WAIT)),
    .i_load_val (step_data - DATA_W'(1)),
    .i_dec      (r_state == StDelay),
    .o_zero     (w_dly_zero)
  );

  seq_countdown #(.W(POLL_W), .RST_VAL(POLL_INIT)) u_poll_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     ((r_state == StFetch) && (step_op == OP_POLL)),
    .i_load_val (POLL_INIT),
    .i_dec      ((r_state == StEval) && (step_op == OP_POLL) && !w_hit),
    .o_zero     (w_poll_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StHold;
      r_step_idx  <= '0;
      r_err_step  <= '0;
      r_err_code  <= ERR_NONE;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_pll_reset <= 1'b0;
      r_if_reset  <= 1'b0;
      r_if_read   <= 1'b0;
      r_if_write  <= 1'b0;
      r_rmw_wr    <= 1'b0;
      r_if_addr   <= '0;
      r_if_wdata  <= '0;
      r_rdata     <= '0;
      for (int k = 0; k < N_CAPT; k++) r_capt[k] <= '0;
    end else begin
      r_if_read  <= 1'b0;
      r_if_write <= 1'b0;
      unique case (r_state)
        StHold: begin
          if (w_hold_zero) begin
            r_state     <= StFetch;
            r_pll_reset <= 1'b1;
            r_if_reset  <= 1'b1;
          end
        end
        StFetch: begin
          r_rmw_wr <= 1'b0;
          case (step_op)
            OP_WRITE, OP_READ, OP_RMW, OP_POLL, OP_CHECK: r_state <= StIssue;
            OP_WAIT: begin
              if (step_data != '0) begin
                r_state <= StDelay;
              end else begin
                r_state    <= w_adv_state;
                r_done     <= w_last;
                r_step_idx <= w_adv_idx;
              end
            end
            OP_END: begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
            default: begin
              r_state    <= w_adv_state;
              r_done     <= w_last;
              r_step_idx <= w_adv_idx;
            end
          endcase
        end
        StIssue: begin
          r_if_addr <= step_addr;
          r_state   <= StWaitDone;
          // The RMW write phase keeps the merged data prepared in EVAL.
          if ((step_op == OP_WRITE) || r_rmw_wr) begin
            r_if_write <= 1'b1;
            if (!r_rmw_wr) r_if_wdata <= step_data;
          end else begin
            r_if_read  <= 1'b1;
            r_if_wdata <= '0;
          end
        end
        StWaitDone: begin
          if (if_done) begin
            r_rdata <= if_rdata;
            r_state <= StEval;
          end else if (w_to_zero) begin
            r_state    <= StFail;
            r_error    <= 1'b1;
            r_err_step <= r_step_idx;
            r_err_code <= ERR_TIMEOUT;
          end
        end
        StEval: begin
          if ((step_op == OP_RMW) && !r_rmw_wr) begin
            r_if_wdata <= (r_rdata & ~step_mask) | (step_data & step_mask);
            r_rmw_wr   <= 1'b1;
            r_state    <= StIssue;
          end else if ((step_op == OP_POLL) && !w_hit) begin
            if (w_poll_zero) begin
              r_state    <= StFail;
              r_error    <= 1'b1;
              r_err_step <= r_step_idx;
              r_err_code <= ERR_POLL;
            end else begin
              r_state <= StIssue;
            end
          end else if ((step_op == OP_CHECK) && !w_hit) begin
            r_state    <= StFail;
            r_error    <= 1'b1;
            r_err_step <= r_step_idx;
            r_err_code <= ERR_CHECK;
          end else begin
            if (step_op == OP_READ) r_capt[step_capt] <= r_rdata;
            r_state    <= w_adv_state;
            r_done     <= w_last;
            r_step_idx <= w_adv_idx;
          end
        end
        StDelay: begin
          if (w_dly_zero) begin
            r_state    <= w_adv_state;
            r_done     <= w_last;
            r_step_idx <= w_adv_idx;
          end
        end
        StDone, StFail: begin
          if (start) begin
            r_state     <= StHold;
            r_step_idx  <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_step  <= '0;
            r_err_code  <= ERR_NONE;
            r_pll_reset <= 1'b0;
            r_if_reset  <= 1'b0;
            for (int k = 0; k < N_CAPT; k++) r_capt[k] <= '0;
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_CAPT; k++) begin : g_capt
    assign capt_data[k*DATA_W +: DATA_W] = r_capt[k];
  end

  assign step_idx  = r_step_idx;
  assign if_read   = r_if_read;
  assign if_write  = r_if_write;
  assign if_addr   = r_if_addr;
  assign if_wdata  = r_if_wdata;
  assign if_reset  = r_if_reset;
  assign pll_reset = r_pll_reset;
  assign busy      = !((r_state == StDone) || (r_state == StFail));
  assign done      = r_done;
  assign error     = r_error;
  assign err_step  = r_err_step;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_pll_spi_sequencer.sv
// Directed bench for pll_spi_sequencer: script ROM and SPI slave are modelled here,
// every expected value is hand-derived.
module tb_pll_spi_sequencer;
  import pll_seq_pkg::*;

  localparam int N_STEPS = 16;
  localparam int N_CAPT  = 8;

  logic        clk, reset_n, start;
  logic [3:0]  step_idx;
  logic [2:0]  step_op;
  logic [7:0]  step_addr, step_data, step_mask;
  logic [2:0]  step_capt;
  logic        if_read, if_write, if_done, if_reset, pll_reset;
  logic [7:0]  if_addr, if_wdata, if_rdata;
  logic [63:0] capt_data;
  logic        busy, done, error;
  logic [3:0]  err_step;
  logic [1:0]  err_code;

  logic [2:0]  s_op   [N_STEPS];
  logic [7:0]  s_addr [N_STEPS];
  logic [7:0]  s_data [N_STEPS];
  logic [7:0]  s_mask [N_STEPS];
  logic [2:0]  s_capt [N_STEPS];

  logic [7:0]  rd_q [$];
  logic [16:0] log_q [$];
  logic [7:0]  rd_default;
  logic        model_en;
  int          n_tests, n_fail;

  assign step_op   = s_op[step_idx];
  assign step_addr = s_addr[step_idx];
  assign step_data = s_data[step_idx];
  assign step_mask = s_mask[step_idx];
  assign step_capt = s_capt[step_idx];

  pll_spi_sequencer #(
    .ADDR_W(8), .DATA_W(8), .N_STEPS(N_STEPS), .N_CAPT(N_CAPT),
    .RESET_WAIT(200), .DONE_TIMEOUT(4096), .POLL_MAX(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .step_idx(step_idx),
    .step_op(step_op), .step_addr(step_addr), .step_data(step_data),
    .step_mask(step_mask), .step_capt(step_capt), .if_read(if_read),
    .if_write(if_write), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_rdata(if_rdata), .if_done(if_done), .if_reset(if_reset),
    .pll_reset(pll_reset), .capt_data(capt_data), .busy(busy), .done(done),
    .error(error), .err_step(err_step), .err_code(err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI slave: logs every request, answers two cycles later when enabled.
  initial begin
    int pend;
    logic [7:0] resp;
    pend = 0; resp = '0; if_done = 1'b0; if_rdata = '0;
    forever begin
      @(negedge clk);
      if_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if_done = 1'b1;
          if_rdata = resp;
        end
      end
      if (if_read || if_write) begin
        log_q.push_back({if_write, if_addr, if_wdata});
        if (if_read) begin
          if (rd_q.size() > 0) resp = rd_q.pop_front();
          else resp = rd_default;
        end
        if (model_en) pend = 2;
      end
    end
  end

  task automatic set_step(input int i, input logic [2:0] op, input logic [7:0] addr,
                          input logic [7:0] data, input logic [7:0] mask, input logic [2:0] capt);
    s_op[i] = op; s_addr[i] = addr; s_data[i] = data; s_mask[i] = mask; s_capt[i] = capt;
  endtask

  task automatic clear_script();
    for (int i = 0; i < N_STEPS; i++) set_step(i, OP_END, 8'h00, 8'h00, 8'h00, 3'd0);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int c;
    c = 0;
    while (!(done || error) && c < budget) begin
      @(posedge clk); #1; c++;
    end
    n_tests++;
    if (!(done || error)) begin
      n_fail++; $display("FAIL wait_end: got busy after %0d cycles, required done or error", c);
    end
  endtask

  task automatic test_reset();
    int low_cyc, first_wr;
    clear_script();
    set_step(0, OP_WRITE, 8'h01, 8'h01, 8'h00, 3'd0);
    set_step(1, OP_RMW,   8'h2B, 8'h02, 8'h02, 3'd0);
    rd_q.delete(); rd_q.push_back(8'hA8); log_q.delete();
    repeat (3) @(negedge clk);
    n_tests++; if ({pll_reset, if_reset, if_read, if_write} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b required 0000", {pll_reset, if_reset, if_read, if_write}); end
    n_tests++; if ({busy, done, error} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags: got %b required 100", {busy, done, error}); end
    n_tests++; if ({if_addr, if_wdata, step_idx, err_step, err_code} !== 28'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h required 0", {if_addr, if_wdata, step_idx, err_step, err_code}); end
    n_tests++; if (capt_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_capt: got %h required 0", capt_data); end
    reset_n = 1'b1;
    low_cyc = -1; first_wr = -1;
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk); #1;
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      if (pll_reset && low_cyc < 0) low_cyc = k;
      if (if_write && first_wr < 0) first_wr = k;
    end
    n_tests++; if (low_cyc != 200) begin
      n_fail++; $display("FAIL pll_reset_low: got %0d cycles required 200", low_cyc); end
    n_tests++; if (first_wr != 202) begin
      n_fail++; $display("FAIL first_strobe: got cycle %0d required 202", first_wr); end
  endtask

  task automatic test_rmw();
    wait_end(500);
    n_tests++; if ({busy, done, error, step_idx} !== 7'b0_1_0_0010) begin
      n_fail++; $display("FAIL rmw_status: got %b required 0100010", {busy, done, error, step_idx}); end
    n_tests++; if (log_q.size() != 3) begin
      n_fail++; $display("FAIL rmw_count: got %0d required 3", log_q.size()); end
    n_tests++; if (log_q[0] !== {1'b1, 8'h01, 8'h01}) begin
      n_fail++; $display("FAIL rmw_w0: got %h required %h", log_q[0], {1'b1, 8'h01, 8'h01}); end
    n_tests++; if (log_q[1][16:8] !== {1'b0, 8'h2B}) begin
      n_fail++; $display("FAIL rmw_rd: got %h required %h", log_q[1][16:8], {1'b0, 8'h2B}); end
    n_tests++; if (log_q[2] !== {1'b1, 8'h2B, 8'hAA}) begin
      n_fail++; $display("FAIL rmw_wr: got %h required %h", log_q[2], {1'b1, 8'h2B, 8'hAA}); end
  endtask

  task automatic test_read();
    clear_script();
    for (int i = 0; i < 4; i++) set_step(i, OP_READ, 8'(8'h02 + i), 8'h00, 8'h00, 3'(i));
    rd_q.delete(); rd_default = 8'hFF; log_q.delete();
    do_start();
    wait_end(500);
    n_tests++; if ({done, error} !== 2'b10) begin
      n_fail++; $display("FAIL read_flags: got %b required 10", {done, error}); end
    n_tests++; if (capt_data !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++; $display("FAIL read_capt: got %h required 00000000ffffffff", capt_data); end
    n_tests++; if (log_q[3][16:8] !== {1'b0, 8'h05} || log_q.size() != 4) begin
      n_fail++; $display("FAIL read_log: got %h/%0d required 005/4", log_q[3][16:8], log_q.size()); end
  endtask

  task automatic test_poll_ok();
    clear_script();
    set_step(0, OP_POLL,  8'h0C, 8'h00, 8'h01, 3'd0);
    set_step(1, OP_WRITE, 8'h10, 8'h5A, 8'h00, 3'd0);
    rd_q.delete(); rd_q.push_back(8'h01); rd_q.push_back(8'h03); rd_q.push_back(8'hFE);
    log_q.delete();
    do_start();
    wait_end(500);
    n_tests++; if ({done, error} !== 2'b10) begin
      n_fail++; $display("FAIL poll_ok_flags: got %b required 10", {done, error}); end
    n_tests++; if (log_q.size() != 4) begin
      n_fail++; $display("FAIL poll_ok_count: got %0d required 4", log_q.size()); end
    n_tests++; if (log_q[2][16:8] !== {1'b0, 8'h0C} || log_q[3] !== {1'b1, 8'h10, 8'h5A}) begin
      n_fail++; $display("FAIL poll_ok_log: got %h %h required 00c %h", log_q[2][16:8], log_q[3],
                         {1'b1, 8'h10, 8'h5A}); end
  endtask

  task automatic test_poll_fail();
    rd_q.delete();
    rd_q.push_back(8'h01); rd_q.push_back(8'h01); rd_q.push_back(8'h01); rd_q.push_back(8'h00);
    log_q.delete();
    do_start();
    wait_end(500);
    n_tests++; if ({done, error, err_code, err_step} !== {2'b01, ERR_POLL, 4'd0}) begin
      n_fail++; $display("FAIL poll_fail: got %b required 01110000", {done, error, err_code, err_step}); end
    n_tests++; if (log_q.size() != 3) begin
      n_fail++; $display("FAIL poll_fail_reads: got %0d required 3", log_q.size()); end
    rd_q.delete();
  endtask

  task automatic test_check();
    clear_script();
    for (int i = 0; i < 4; i++) set_step(i, OP_WRITE, 8'(8'h20 + i), 8'(i), 8'h00, 3'd0);
    set_step(4, OP_READ,  8'h24, 8'h00, 8'h00, 3'd7);
    set_step(5, OP_CHECK, 8'h30, 8'h55, 8'hFF, 3'd0);
    rd_default = 8'h54; log_q.delete();
    do_start();
    wait_end(500);
    n_tests++; if ({busy, done, error} !== 3'b001) begin
      n_fail++; $display("FAIL check_flags: got %b required 001", {busy, done, error}); end
    n_tests++; if (err_step !== 4'd5 || err_code !== ERR_CHECK) begin
      n_fail++; $display("FAIL check_err: got step %0d code %0d required step 5 code 2", err_step, err_code); end
    n_tests++; if (capt_data[63:56] !== 8'h54) begin
      n_fail++; $display("FAIL check_capt: got %h required 54", capt_data[63:56]); end
    rd_default = 8'h55;
    do_start();
    n_tests++; if ({busy, error, err_step, err_code, pll_reset, if_reset} !== 10'b10_0000_00_00) begin
      n_fail++; $display("FAIL restart_clear: got %b required 1000000000",
                         {busy, error, err_step, err_code, pll_reset, if_reset}); end
    n_tests++; if (capt_data !== 64'h0) begin
      n_fail++; $display("FAIL restart_capt: got %h required 0", capt_data); end
    wait_end(500);
    n_tests++; if ({done, error, capt_data[63:56]} !== {2'b10, 8'h55}) begin
      n_fail++; $display("FAIL check_pass: got %h required 255", {done, error, capt_data[63:56]}); end
  endtask

  task automatic test_wait();
    int first;
    clear_script();
    set_step(0, OP_WAIT,  8'h00, 8'h00, 8'h00, 3'd0);
    set_step(1, OP_WAIT,  8'h00, 8'h05, 8'h00, 3'd0);
    set_step(2, OP_WRITE, 8'h40, 8'hC5, 8'h00, 3'd0);
    log_q.delete();
    do_start();
    first = -1;
    for (int k = 1; k <= 300 && first < 0; k++) begin
      @(posedge clk); #1;
      if (if_read || if_write) first = k;
    end
    n_tests++; if (first != 209) begin
      n_fail++; $display("FAIL wait_delay: got first strobe at %0d required 209", first); end
    wait_end(100);
    n_tests++; if (log_q.size() != 1 || log_q[0] !== {1'b1, 8'h40, 8'hC5} || done !== 1'b1) begin
      n_fail++; $display("FAIL wait_log: got %h/%0d done %b required 140c5/1 done 1",
                         log_q[0], log_q.size(), done); end
  endtask

  task automatic test_back_to_back();
    clear_script();
    set_step(0, OP_READ, 8'h50, 8'h00, 8'h00, 3'd2);
    set_step(1, OP_READ, 8'h51, 8'h00, 8'h00, 3'd5);
    for (int i = 2; i < N_STEPS; i++) set_step(i, OP_WRITE, 8'(8'h60 + i), 8'(i), 8'h00, 3'd0);
    rd_q.delete(); rd_q.push_back(8'h3C); rd_q.push_back(8'hC3); log_q.delete();
    do_start();
    wait_end(800);
    n_tests++; if ({done, error, step_idx} !== 6'b10_1111) begin
      n_fail++; $display("FAIL b2b_end: got %b required 101111", {done, error, step_idx}); end
    n_tests++; if (capt_data !== 64'h0000_C300_003C_0000) begin
      n_fail++; $display("FAIL b2b_capt: got %h required 0000c300003c0000", capt_data); end
    n_tests++; if (log_q.size() != 16 || log_q[15] !== {1'b1, 8'h6F, 8'h0F}) begin
      n_fail++; $display("FAIL b2b_log: got %h/%0d required 16f0f/16", log_q[15], log_q.size()); end
  endtask

  task automatic test_timeout();
    int k_s, k_e;
    clear_script();
    set_step(0, OP_READ, 8'h41, 8'h00, 8'h00, 3'd0);
    model_en = 1'b0;
    do_start();
    k_s = -1; k_e = -1;
    for (int k = 1; k <= 4600 && k_e < 0; k++) begin
      @(posedge clk); #1;
      if (if_read && k_s < 0) k_s = k;
      if (error && k_e < 0) k_e = k;
    end
    n_tests++; if (k_s != 202 || (k_e - k_s) != 4096) begin
      n_fail++; $display("FAIL timeout_cycles: got strobe %0d error %0d required 202 4298", k_s, k_e); end
    n_tests++; if ({error, err_code, err_step} !== {1'b1, ERR_TIMEOUT, 4'd0}) begin
      n_fail++; $display("FAIL timeout_code: got %b required 1010000", {error, err_code, err_step}); end
    model_en = 1'b1;
  endtask

  task automatic test_abort();
    int nstb, k;
    clear_script();
    set_step(0, OP_WRITE, 8'h70, 8'h07, 8'h00, 3'd0);
    set_step(1, OP_READ,  8'h71, 8'h00, 8'h00, 3'd0);
    do_start();
    nstb = 0; k = 0;
    while (nstb < 2 && k < 400) begin
      @(posedge clk); #1; k++;
      if (if_read || if_write) nstb++;
    end
    n_tests++; if (nstb != 2 || if_read !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: got %0d strobes read %b required 2 read 1", nstb, if_read); end
    reset_n = 1'b0;
    #1;
    n_tests++; if ({if_read, if_write, pll_reset, if_reset, busy, done} !== 6'b000010) begin
      n_fail++; $display("FAIL abort_ctl: got %b required 000010",
                         {if_read, if_write, pll_reset, if_reset, busy, done}); end
    n_tests++; if ({if_addr, if_wdata, step_idx} !== 20'h0) begin
      n_fail++; $display("FAIL abort_regs: got %h required 0", {if_addr, if_wdata, step_idx}); end
    @(negedge clk); reset_n = 1'b1;
    wait_end(600);
    n_tests++; if ({done, error, step_idx} !== 6'b10_0010) begin
      n_fail++; $display("FAIL abort_rerun: got %b required 100010", {done, error, step_idx}); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; model_en = 1'b1; rd_default = 8'h00;
    test_reset();
    test_rmw();
    test_read();
    test_poll_ok();
    test_poll_fail();
    test_check();
    test_wait();
    test_back_to_back();
    test_timeout();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run by 2000000, required earlier");
    $fatal(1, "watchdog");
  end

endmodule
